// File: rtl/ptw_pkg.sv
// Shared types and constants for the page-table-walk AXI read port.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ptw_pkg;

    // Walk sequencer states: arbitrate, address phase, data phase, response pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } ptw_state_t;

    // Which TLB walker owns the current (or most recent) walk.
    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } ptw_req_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] PTE_ARSIZE     = 3'd3;   // 8-byte PTE, one beat
    localparam logic [2:0] PTE_ARPROT     = 3'b001; // privileged, secure, data

endpackage

// File: rtl/ptw_req_capture.sv
// Per-requester pulse latch: remembers one pending PTE fetch and its address.
// Latency: pend/addr valid the cycle after the request pulse.
// Backpressure: none; a new pulse while pending overwrites the address (last wins).
//
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   req_valid    one-cycle fetch pulse from the TLB walker
//   req_addr     PTE address accompanying the pulse
//   grant_clr    arbiter has taken this request; drop the pending flag
//   pend         request waiting for arbitration
//   addr         latched PTE address
module ptw_req_capture #(
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  grant_clr,
    output logic                  pend,
    output logic [ADDR_WIDTH-1:0] addr
);

    // A pulse in the same cycle as the grant is a new request: the grant
    // consumed the old address, so the set must win over the clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend <= 1'b0;
            addr <= '0;
        end else if (req_valid) begin
            pend <= 1'b1;
            addr <= req_addr;
        end else if (grant_clr) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/ptw_axi_read_port.sv
// Shared PTW memory port: round-robin ITLB/DTLB walks onto single-beat AXI4 reads.
// Latency: grant=0, ARVALID=1, R accepted at first RVALID after AR, response pulse the cycle after.
// Backpressure: ARVALID held until ARREADY; one walk outstanding; requests queue one deep per TLB.
//
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   I_REQ_*/D_REQ_*                one-cycle PTE fetch pulses + address from each TLB
//   I_RESP_*/D_RESP_*              one-cycle PTE return pulse, data, access fault
//   M_AR*                          AXI4 read address channel (master)
//   M_R*                           AXI4 read data channel (master)
// Build option: define PTW_RRESP_ERR_EN to report SLVERR/DECERR on *_RESP_ERR
// instead of returning the beat as valid data.
module ptw_axi_read_port
    import ptw_pkg::*;
#(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int AXI_ID_WIDTH = 4,
    parameter int I_ARID       = 0,
    parameter int D_ARID       = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    I_REQ_VALID,
    input  logic [ADDR_WIDTH-1:0]   I_REQ_ADDR,
    output logic                    I_RESP_VALID,
    output logic [DATA_WIDTH-1:0]   I_RESP_DATA,
    output logic                    I_RESP_ERR,
    input  logic                    D_REQ_VALID,
    input  logic [ADDR_WIDTH-1:0]   D_REQ_ADDR,
    output logic                    D_RESP_VALID,
    output logic [DATA_WIDTH-1:0]   D_RESP_DATA,
    output logic                    D_RESP_ERR,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,
    output logic [ADDR_WIDTH-1:0]   M_ARADDR,
    output logic [AXI_ID_WIDTH-1:0] M_ARID,
    output logic [7:0]              M_ARLEN,
    output logic [2:0]              M_ARSIZE,
    output logic [1:0]              M_ARBURST,
    output logic [2:0]              M_ARPROT,
    input  logic                    M_RVALID,
    output logic                    M_RREADY,
    input  logic [DATA_WIDTH-1:0]   M_RDATA,
    input  logic [AXI_ID_WIDTH-1:0] M_RID,
    input  logic [1:0]              M_RRESP,
    input  logic                    M_RLAST
);

    localparam logic [AXI_ID_WIDTH-1:0] I_ID = I_ARID[AXI_ID_WIDTH-1:0];
    localparam logic [AXI_ID_WIDTH-1:0] D_ID = D_ARID[AXI_ID_WIDTH-1:0];

    ptw_state_t            state_q, state_d;
    ptw_req_t              last_grant_q;
    ptw_req_t              owner_q;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [AXI_ID_WIDTH-1:0] ar_id_q;
    logic [DATA_WIDTH-1:0] i_data_q, d_data_q;
    logic                  rsp_err;

    logic                  pend_i, pend_d;
    logic [ADDR_WIDTH-1:0] addr_i, addr_d;
    logic                  grant_i, grant_d;
    logic                  ar_hs, r_hs, r_ok;

    ptw_req_capture #(.ADDR_WIDTH(ADDR_WIDTH)) u_cap_i (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (I_REQ_VALID),
        .req_addr  (I_REQ_ADDR),
        .grant_clr (grant_i),
        .pend      (pend_i),
        .addr      (addr_i)
    );

    ptw_req_capture #(.ADDR_WIDTH(ADDR_WIDTH)) u_cap_d (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (D_REQ_VALID),
        .req_addr  (D_REQ_ADDR),
        .grant_clr (grant_d),
        .pend      (pend_d),
        .addr      (addr_d)
    );

    // Round-robin: on a tie, the requester not served last time wins.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == IDLE) begin
            if (pend_i && (!pend_d || last_grant_q == REQ_D)) begin
                grant_i = 1'b1;
            end else if (pend_d) begin
                grant_d = 1'b1;
            end
        end
    end

    assign ar_hs = M_ARVALID && M_ARREADY;
    assign r_hs  = M_RVALID && M_RREADY;

    // Only one read is ever outstanding, so RID/RLAST carry no information.
`ifdef PTW_RRESP_ERR_EN
    assign r_ok = (M_RRESP == AXI_RESP_OKAY);
    logic unused_inputs;
    assign unused_inputs = ^{M_RID, M_RLAST, addr_i[2:0], addr_d[2:0]};
`else
    assign r_ok = 1'b1;
    logic unused_inputs;
    assign unused_inputs = ^{M_RID, M_RLAST, M_RRESP, addr_i[2:0], addr_d[2:0]};
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (grant_i || grant_d) state_d = ADDR;
            ADDR: if (ar_hs)              state_d = DATA;
            DATA: if (r_hs)               state_d = RESP;
            RESP:                         state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant_q <= REQ_D;
            owner_q      <= REQ_I;
            ar_addr_q    <= '0;
            ar_id_q      <= '0;
            i_data_q     <= '0;
            d_data_q     <= '0;
        end else begin
            if (grant_i) begin
                last_grant_q <= REQ_I;
                owner_q      <= REQ_I;
                ar_addr_q    <= {addr_i[ADDR_WIDTH-1:3], 3'b000};
                ar_id_q      <= I_ID;
            end else if (grant_d) begin
                last_grant_q <= REQ_D;
                owner_q      <= REQ_D;
                ar_addr_q    <= {addr_d[ADDR_WIDTH-1:3], 3'b000};
                ar_id_q      <= D_ID;
            end
            // Faulted beats leave the previous PTE in place.
            if (r_hs && r_ok) begin
                if (owner_q == REQ_I) i_data_q <= M_RDATA;
                else                  d_data_q <= M_RDATA;
            end
        end
    end

`ifdef PTW_RRESP_ERR_EN
    logic err_q;
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (r_hs) begin
            err_q <= !r_ok;
        end
    end
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // ---------------- FSM: outputs ----------------
    // Static AR fields are only driven while the address is presented, so
    // the whole AR channel reads as zero out of reset.
    always_comb begin
        M_ARVALID    = (state_q == ADDR);
        M_ARADDR     = ar_addr_q;
        M_ARID       = ar_id_q;
        M_ARLEN      = 8'd0;
        M_ARSIZE     = M_ARVALID ? PTE_ARSIZE     : 3'd0;
        M_ARBURST    = M_ARVALID ? AXI_BURST_INCR : 2'd0;
        M_ARPROT     = M_ARVALID ? PTE_ARPROT     : 3'd0;
        M_RREADY     = (state_q == DATA);
        I_RESP_VALID = (state_q == RESP) && (owner_q == REQ_I) && !rsp_err;
        D_RESP_VALID = (state_q == RESP) && (owner_q == REQ_D) && !rsp_err;
        I_RESP_ERR   = (state_q == RESP) && (owner_q == REQ_I) && rsp_err;
        D_RESP_ERR   = (state_q == RESP) && (owner_q == REQ_D) && rsp_err;
        I_RESP_DATA  = i_data_q;
        D_RESP_DATA  = d_data_q;
    end

endmodule

// File: tb/tb_ptw_axi_read_port.sv
// Directed bench for ptw_axi_read_port with a hand-driven AXI slave.
// Latency: n/a.
// Backpressure: ARREADY stalls driven explicitly by the stimulus.
module tb_ptw_axi_read_port;

    logic        CLK = 1'b0;
    logic        RST;
    logic        I_REQ_VALID, D_REQ_VALID;
    logic [63:0] I_REQ_ADDR, D_REQ_ADDR;
    logic        I_RESP_VALID, D_RESP_VALID, I_RESP_ERR, D_RESP_ERR;
    logic [63:0] I_RESP_DATA, D_RESP_DATA;
    logic        M_ARVALID, M_ARREADY;
    logic [63:0] M_ARADDR;
    logic [3:0]  M_ARID;
    logic [7:0]  M_ARLEN;
    logic [2:0]  M_ARSIZE;
    logic [1:0]  M_ARBURST;
    logic [2:0]  M_ARPROT;
    logic        M_RVALID, M_RREADY, M_RLAST;
    logic [63:0] M_RDATA;
    logic [3:0]  M_RID;
    logic [1:0]  M_RRESP;

    int n_cmp = 0;
    int n_err = 0;
    int lat;

    always #5 CLK = ~CLK;

    ptw_axi_read_port dut (
        .CLK(CLK), .RST(RST),
        .I_REQ_VALID(I_REQ_VALID), .I_REQ_ADDR(I_REQ_ADDR),
        .I_RESP_VALID(I_RESP_VALID), .I_RESP_DATA(I_RESP_DATA), .I_RESP_ERR(I_RESP_ERR),
        .D_REQ_VALID(D_REQ_VALID), .D_REQ_ADDR(D_REQ_ADDR),
        .D_RESP_VALID(D_RESP_VALID), .D_RESP_DATA(D_RESP_DATA), .D_RESP_ERR(D_RESP_ERR),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR), .M_ARID(M_ARID),
        .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST), .M_ARPROT(M_ARPROT),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA),
        .M_RID(M_RID), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic pulse(input bit vi, input logic [63:0] ai, input bit vd, input logic [63:0] ad);
        I_REQ_VALID = vi; I_REQ_ADDR = ai;
        D_REQ_VALID = vd; D_REQ_ADDR = ad;
        @(negedge CLK);
        I_REQ_VALID = 1'b0;
        D_REQ_VALID = 1'b0;
    endtask

    // Waits (bounded) for ARVALID, holds ARREADY low for 'stall' cycles while
    // checking the address is stable, then completes the handshake.
    // Returns in the DATA phase, on a falling edge.
    task automatic ar_phase(input logic [63:0] exp_addr, input logic [3:0] exp_id,
                            input int stall, output int n);
        n = 0;
        while (!M_ARVALID && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("arvalid_seen", {63'd0, M_ARVALID}, 64'd1);
        chk("araddr", M_ARADDR, exp_addr);
        chk("arid", {60'd0, M_ARID}, {60'd0, exp_id});
        chk("arlen_size_burst_prot", {51'd0, M_ARLEN, M_ARSIZE, M_ARBURST}, {51'd0, 8'd0, 3'd3, 2'b01});
        chk("arprot", {61'd0, M_ARPROT}, 64'd1);
        for (int s = 0; s < stall; s++) begin
            chk("stall_arvalid", {63'd0, M_ARVALID}, 64'd1);
            chk("stall_araddr", M_ARADDR, exp_addr);
            chk("stall_arid", {60'd0, M_ARID}, {60'd0, exp_id});
            @(negedge CLK);
        end
        M_ARREADY = 1'b1;
        @(negedge CLK);
        M_ARREADY = 1'b0;
        chk("ar_dropped", {63'd0, M_ARVALID}, 64'd0);
        chk("rready_in_data", {63'd0, M_RREADY}, 64'd1);
    endtask

    // Presents one R beat from the DATA phase and checks the response pulse.
    task automatic r_phase(input bit own_d, input logic [63:0] rdata, input logic [1:0] rresp,
                           input bit exp_vld, input bit exp_err, input logic [63:0] exp_data);
        M_RVALID = 1'b1; M_RDATA = rdata; M_RRESP = rresp;
        @(negedge CLK);
        M_RVALID = 1'b0;
        chk("rready_after_beat", {63'd0, M_RREADY}, 64'd0);
        if (own_d) begin
            chk("d_resp_valid", {63'd0, D_RESP_VALID}, {63'd0, exp_vld});
            chk("d_resp_err", {63'd0, D_RESP_ERR}, {63'd0, exp_err});
            chk("d_resp_data", D_RESP_DATA, exp_data);
            chk("i_quiet", {62'd0, I_RESP_VALID, I_RESP_ERR}, 64'd0);
        end else begin
            chk("i_resp_valid", {63'd0, I_RESP_VALID}, {63'd0, exp_vld});
            chk("i_resp_err", {63'd0, I_RESP_ERR}, {63'd0, exp_err});
            chk("i_resp_data", I_RESP_DATA, exp_data);
            chk("d_quiet", {62'd0, D_RESP_VALID, D_RESP_ERR}, 64'd0);
        end
    endtask

    initial begin
        RST = 1'b1;
        I_REQ_VALID = 1'b0; I_REQ_ADDR = '0;
        D_REQ_VALID = 1'b0; D_REQ_ADDR = '0;
        M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RDATA = '0;
        M_RID = '0; M_RRESP = 2'b00; M_RLAST = 1'b1;
        repeat (3) @(negedge CLK);

        // Reset state: every output zero.
        chk("rst_ar", {M_ARVALID, M_ARID, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARPROT, M_RREADY}, 64'd0);
        chk("rst_araddr", M_ARADDR, 64'd0);
        chk("rst_resp", {60'd0, I_RESP_VALID, I_RESP_ERR, D_RESP_VALID, D_RESP_ERR}, 64'd0);
        chk("rst_idata", I_RESP_DATA, 64'd0);
        chk("rst_ddata", D_RESP_DATA, 64'd0);
        RST = 1'b0;

        // Single D walk, zero-wait slave: ARVALID one cycle after the grant.
        pulse(1'b0, 64'd0, 1'b1, 64'h8000_1238);
        ar_phase(64'h8000_1238, 4'd1, 0, lat);
        chk("t1_ar_latency", 64'(lat), 64'd1);
        r_phase(1'b1, 64'h0000_0000_2000_00CF, 2'b00, 1'b1, 1'b0, 64'h0000_0000_2000_00CF);
        @(negedge CLK);
        chk("t1_pulse_one_cycle", {62'd0, D_RESP_VALID, I_RESP_VALID}, 64'd0);
        chk("t1_data_holds", D_RESP_DATA, 64'h0000_0000_2000_00CF);

        // Tie straight after reset: I first, then D (unaligned address rounds down).
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rst2_ddata", D_RESP_DATA, 64'd0);
        pulse(1'b1, 64'h1000, 1'b1, 64'h2007);
        ar_phase(64'h1000, 4'd0, 0, lat);
        r_phase(1'b0, 64'h11, 2'b00, 1'b1, 1'b0, 64'h11);
        ar_phase(64'h2000, 4'd1, 0, lat);
        chk("t2_b2b_latency", 64'(lat), 64'd2);
        r_phase(1'b1, 64'h22, 2'b00, 1'b1, 1'b0, 64'h22);
        // A lone I walk makes I the last grant; the next tie goes to D.
        pulse(1'b1, 64'h1800, 1'b0, 64'd0);
        ar_phase(64'h1800, 4'd0, 0, lat);
        r_phase(1'b0, 64'h33, 2'b00, 1'b1, 1'b0, 64'h33);
        pulse(1'b1, 64'h1900, 1'b1, 64'h2900);
        ar_phase(64'h2900, 4'd1, 0, lat);
        r_phase(1'b1, 64'h44, 2'b00, 1'b1, 1'b0, 64'h44);
        ar_phase(64'h1900, 4'd0, 0, lat);
        r_phase(1'b0, 64'h55, 2'b00, 1'b1, 1'b0, 64'h55);

        // ARREADY low for 5 cycles: address stable, one handshake, one response.
        pulse(1'b1, 64'h3008, 1'b0, 64'd0);
        ar_phase(64'h3008, 4'd0, 5, lat);
        r_phase(1'b0, 64'h66, 2'b00, 1'b1, 1'b0, 64'h66);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("t3_quiet", {61'd0, M_ARVALID, I_RESP_VALID, D_RESP_VALID}, 64'd0);
        end

        // D overwrites its pending address during an I walk; an I request
        // arriving with I's response pulse is kept.
        pulse(1'b1, 64'h4000, 1'b0, 64'd0);
        ar_phase(64'h4000, 4'd0, 0, lat);
        pulse(1'b0, 64'd0, 1'b1, 64'h100);
        pulse(1'b0, 64'd0, 1'b1, 64'h200);
        r_phase(1'b0, 64'h77, 2'b00, 1'b1, 1'b0, 64'h77);
        pulse(1'b1, 64'h5000, 1'b0, 64'd0);
        ar_phase(64'h200, 4'd1, 0, lat);
        r_phase(1'b1, 64'h88, 2'b00, 1'b1, 1'b0, 64'h88);
        ar_phase(64'h5000, 4'd0, 0, lat);
        r_phase(1'b0, 64'h99, 2'b00, 1'b1, 1'b0, 64'h99);

        // Reset during DATA with a D request pending: everything dropped.
        pulse(1'b1, 64'h6000, 1'b0, 64'd0);
        ar_phase(64'h6000, 4'd0, 0, lat);
        pulse(1'b0, 64'd0, 1'b1, 64'h7000);
        RST = 1'b1;
        M_RVALID = 1'b1; M_RDATA = 64'hBAD;
        @(negedge CLK);
        RST = 1'b0;
        M_RVALID = 1'b0;
        chk("t5_after_rst", {60'd0, M_ARVALID, M_RREADY, I_RESP_VALID, D_RESP_VALID}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("t5_no_pending", {61'd0, M_ARVALID, I_RESP_VALID, D_RESP_VALID}, 64'd0);
        end
        pulse(1'b0, 64'd0, 1'b1, 64'h7100);
        ar_phase(64'h7100, 4'd1, 0, lat);
        r_phase(1'b1, 64'hAA, 2'b00, 1'b1, 1'b0, 64'hAA);

        // SLVERR response.
        pulse(1'b0, 64'd0, 1'b1, 64'h7200);
        ar_phase(64'h7200, 4'd1, 0, lat);
`ifdef PTW_RRESP_ERR_EN
        r_phase(1'b1, 64'hBB, 2'b10, 1'b0, 1'b1, 64'hAA);
`else
        r_phase(1'b1, 64'hBB, 2'b10, 1'b1, 1'b0, 64'hBB);
`endif
        @(negedge CLK);
        chk("t6_quiet", {62'd0, D_RESP_VALID, D_RESP_ERR}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
